// File: rtl/fetch_unit.sv
// Instruction fetch stage for the single-cycle RV32I core: owns the PC, fetches
// one instruction per retire over a req/ack handshake and computes the next PC.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic        CLK,
    input  logic        RST,
    output logic [31:0] IMEM_ADDR,
    output logic        IMEM_REQ,
    input  logic [31:0] IMEM_RDATA,
    input  logic        IMEM_ACK,
    input  logic        RETIRE,
    input  logic        PC_SRC,
    input  logic        JALR,
    input  logic [31:0] BR_TARGET,
    input  logic [31:0] JALR_TARGET,
    output logic [31:0] PC,
    output logic [31:0] PC_PLUS4,
    output logic [31:0] INSTR,
    output logic        INSTR_VALID,
    output logic [6:0]  OPCODE,
    output logic [2:0]  FUNCT3,
    output logic        FUNCT7,
    output logic        MISALIGN,
    output logic        FETCH_ERR
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_ISSUE = 2'd2;
    localparam logic [1:0] S_HALT  = 2'd3;

    localparam int unsigned     CNT_W       = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);
    localparam bit              TIMEOUT_EN  = (TIMEOUT != 0);

    logic [1:0]       state, state_nxt;
    logic [31:0]      pc, pc_nxt;
    logic [31:0]      instr, instr_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
    logic             misalign, misalign_nxt;
    logic             fetch_err, fetch_err_nxt;
    logic [31:0]      seq_pc, jalr_pc, next_pc;
    logic             valid;

    assign seq_pc  = pc + 32'd4;
    // JALR clears bit 0 of the computed target before alignment is judged
    assign jalr_pc = JALR_TARGET & ~32'd1;
    assign next_pc = !PC_SRC ? seq_pc : (JALR ? jalr_pc : BR_TARGET);
    assign cnt_inc = cnt + 1'b1;

    always_comb begin
        state_nxt     = state;
        pc_nxt        = pc;
        instr_nxt     = instr;
        cnt_nxt       = cnt;
        misalign_nxt  = misalign;
        fetch_err_nxt = fetch_err;
        case (state)
            S_IDLE: state_nxt = S_FETCH;
            S_FETCH: begin
                if (IMEM_ACK) begin
                    instr_nxt = IMEM_RDATA;
                    cnt_nxt   = '0;
                    state_nxt = S_ISSUE;
                end else begin
                    cnt_nxt = cnt_inc;
                    if (TIMEOUT_EN && (cnt_inc == TIMEOUT_CNT)) begin
                        fetch_err_nxt = 1'b1;
                        state_nxt     = S_HALT;
                    end
                end
            end
            S_ISSUE: begin
                if (RETIRE) begin
                    if (next_pc[1:0] != 2'b00) begin
                        misalign_nxt = 1'b1;
                        state_nxt    = S_HALT;
                    end else begin
                        pc_nxt    = next_pc;
                        state_nxt = S_FETCH;
                    end
                end
            end
            default: state_nxt = S_HALT;  // HALT leaves only through reset
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state     <= S_IDLE;
            pc        <= RESET_PC;
            instr     <= '0;
            cnt       <= '0;
            misalign  <= 1'b0;
            fetch_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            pc        <= pc_nxt;
            instr     <= instr_nxt;
            cnt       <= cnt_nxt;
            misalign  <= misalign_nxt;
            fetch_err <= fetch_err_nxt;
        end
    end

    // Fields read as zero between instructions so the control unit idles
    assign valid       = (state == S_ISSUE);
    assign INSTR_VALID = valid;
    assign IMEM_REQ    = (state == S_FETCH);
    assign IMEM_ADDR   = pc;
    assign PC          = pc;
    assign PC_PLUS4    = seq_pc;
    assign INSTR       = instr;
    assign OPCODE      = valid ? instr[6:0]   : 7'd0;
    assign FUNCT3      = valid ? instr[14:12] : 3'd0;
    assign FUNCT7      = valid ? instr[30]    : 1'b0;
    assign MISALIGN    = misalign;
    assign FETCH_ERR   = fetch_err;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed stimulus pushes expected issues into a queue,
// a monitor pops and checks each newly presented instruction.
module tb_fetch_unit;

    logic        CLK, RST;
    logic [31:0] IMEM_ADDR, IMEM_RDATA, BR_TARGET, JALR_TARGET;
    logic [31:0] PC, PC_PLUS4, INSTR;
    logic        IMEM_REQ, IMEM_ACK, RETIRE, PC_SRC, JALR;
    logic        INSTR_VALID, FUNCT7, MISALIGN, FETCH_ERR;
    logic [6:0]  OPCODE;
    logic [2:0]  FUNCT3;

    fetch_unit #(.RESET_PC(32'h0000_0000), .TIMEOUT(4)) dut (
        .CLK(CLK), .RST(RST),
        .IMEM_ADDR(IMEM_ADDR), .IMEM_REQ(IMEM_REQ), .IMEM_RDATA(IMEM_RDATA), .IMEM_ACK(IMEM_ACK),
        .RETIRE(RETIRE), .PC_SRC(PC_SRC), .JALR(JALR),
        .BR_TARGET(BR_TARGET), .JALR_TARGET(JALR_TARGET),
        .PC(PC), .PC_PLUS4(PC_PLUS4), .INSTR(INSTR), .INSTR_VALID(INSTR_VALID),
        .OPCODE(OPCODE), .FUNCT3(FUNCT3), .FUNCT7(FUNCT7),
        .MISALIGN(MISALIGN), .FETCH_ERR(FETCH_ERR)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic        funct7;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   ack_delay = 0;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h at %0t", name, act, want, $time);
        end
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] instr,
                        input logic [6:0] op, input logic [2:0] f3, input logic f7);
        exp_t e;
        e.pc = pc; e.instr = instr; e.opcode = op; e.funct3 = f3; e.funct7 = f7;
        exp_q.push_back(e);
    endtask

    task automatic push_nop(input logic [31:0] pc);
        push(pc, 32'h0000_0013, 7'h13, 3'd0, 1'b0);
    endtask

    task automatic chk_reset();
        chk("rst_pc", PC, 32'h0);
        chk("rst_pc_plus4", PC_PLUS4, 32'h4);
        chk("rst_addr", IMEM_ADDR, 32'h0);
        chk("rst_req", {31'd0, IMEM_REQ}, 32'd0);
        chk("rst_valid", {31'd0, INSTR_VALID}, 32'd0);
        chk("rst_instr", INSTR, 32'h0);
        chk("rst_fields", {21'd0, OPCODE, FUNCT3, FUNCT7}, 32'd0);
        chk("rst_misalign", {31'd0, MISALIGN}, 32'd0);
        chk("rst_fetch_err", {31'd0, FETCH_ERR}, 32'd0);
    endtask

    // Instruction memory: words chosen so opcode/funct3/funct7 differ by address
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0040: return 32'h40B5_5533;  // sra a0,a0,a1
            32'h0000_0100: return 32'h0041_5093;  // srli x1,x2,4
            default:       return 32'h0000_0013;  // nop
        endcase
    endfunction

    // Memory responder: acks after ack_delay waiting FETCH cycles
    initial begin
        int wc;
        wc = 0;
        IMEM_ACK = 1'b0;
        IMEM_RDATA = 32'h0;
        forever begin
            @(negedge CLK);
            if (!IMEM_REQ) begin
                IMEM_ACK = 1'b0;
                wc = 0;
            end else if (wc == ack_delay) begin
                IMEM_ACK = 1'b1;
                IMEM_RDATA = mem_word(IMEM_ADDR);
                wc = 0;
            end else begin
                IMEM_ACK = 1'b0;
                IMEM_RDATA = 32'hDEAD_BEEF;
                wc++;
            end
        end
    end

    // Monitor: field gating every cycle, scoreboard pop on each new issue
    initial begin
        logic prev_valid;
        exp_t e;
        prev_valid = 1'b0;
        forever begin
            @(negedge CLK);
            if (!INSTR_VALID) begin
                chk("gated_fields", {21'd0, OPCODE, FUNCT3, FUNCT7}, 32'd0);
            end else if (!prev_valid) begin
                if (exp_q.size() == 0) begin
                    errors++;
                    checks++;
                    $display("FAIL unexpected_issue: pc %h instr %h with empty queue", PC, INSTR);
                end else begin
                    e = exp_q.pop_front();
                    chk("issue_pc", PC, e.pc);
                    chk("issue_pc_plus4", PC_PLUS4, e.pc + 32'd4);
                    chk("issue_instr", INSTR, e.instr);
                    chk("issue_opcode", {25'd0, OPCODE}, {25'd0, e.opcode});
                    chk("issue_funct3", {29'd0, FUNCT3}, {29'd0, e.funct3});
                    chk("issue_funct7", {31'd0, FUNCT7}, {31'd0, e.funct7});
                end
            end
            prev_valid = INSTR_VALID;
        end
    end

    initial begin
        RST = 1'b0; RETIRE = 1'b0; PC_SRC = 1'b0; JALR = 1'b0;
        BR_TARGET = 32'h0; JALR_TARGET = 32'h0;
        repeat (3) @(negedge CLK);
        #1 chk_reset();

        // Sequential stream, zero-wait memory, RETIRE held high
        for (int i = 0; i < 5; i++) push_nop(32'(i * 4));
        RETIRE = 1'b1;
        RST = 1'b1;
        #1 chk("idle_req", {31'd0, IMEM_REQ}, 32'd0);
        for (int k = 1; k <= 9; k++) begin
            @(negedge CLK);
            chk("seq_valid", {31'd0, INSTR_VALID}, {31'd0, (k % 2) == 0});
            chk("seq_req", {31'd0, IMEM_REQ}, {31'd0, (k % 2) == 1});
            chk("seq_addr", IMEM_ADDR, 32'((k - 1) / 2 * 4));
        end

        // Branch redirect from 0x10 to 0x40
        @(negedge CLK);
        chk("br_pc_plus4", PC_PLUS4, 32'h14);
        PC_SRC = 1'b1; BR_TARGET = 32'h40;
        push(32'h40, 32'h40B5_5533, 7'h33, 3'd5, 1'b1);
        @(negedge CLK);
        chk("br_addr", IMEM_ADDR, 32'h40);
        PC_SRC = 1'b0;

        // JALR redirect: target 0x101 has bit 0 cleared
        @(negedge CLK);
        chk("jalr_issue_valid", {31'd0, INSTR_VALID}, 32'd1);
        PC_SRC = 1'b1; JALR = 1'b1; JALR_TARGET = 32'h101;
        push(32'h100, 32'h0041_5093, 7'h13, 3'd5, 1'b0);
        @(negedge CLK);
        chk("jalr_addr", IMEM_ADDR, 32'h100);
        chk("jalr_misalign", {31'd0, MISALIGN}, 32'd0);
        PC_SRC = 1'b0; JALR = 1'b0;

        // Misaligned branch halts with PC unchanged
        @(negedge CLK);
        PC_SRC = 1'b1; BR_TARGET = 32'h102;
        @(negedge CLK);
        chk("mis_flag", {31'd0, MISALIGN}, 32'd1);
        chk("mis_req", {31'd0, IMEM_REQ}, 32'd0);
        chk("mis_valid", {31'd0, INSTR_VALID}, 32'd0);
        chk("mis_pc", PC, 32'h100);
        repeat (4) @(negedge CLK);
        chk("halt_req", {31'd0, IMEM_REQ}, 32'd0);
        chk("halt_misalign", {31'd0, MISALIGN}, 32'd1);
        chk("halt_pc", PC, 32'h100);

        // Timeout with ACK never arriving
        PC_SRC = 1'b0; RETIRE = 1'b0; ack_delay = 255;
        RST = 1'b0;
        #1 chk_reset();
        @(negedge CLK);
        RST = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge CLK);
            chk("to_req", {31'd0, IMEM_REQ}, 32'd1);
            chk("to_err_early", {31'd0, FETCH_ERR}, 32'd0);
        end
        @(negedge CLK);
        chk("to_err", {31'd0, FETCH_ERR}, 32'd1);
        chk("to_req_drop", {31'd0, IMEM_REQ}, 32'd0);
        repeat (3) @(negedge CLK);
        chk("to_err_sticky", {31'd0, FETCH_ERR}, 32'd1);
        chk("to_req_halt", {31'd0, IMEM_REQ}, 32'd0);

        // ACK on the third FETCH cycle, twice in a row: no timeout
        RST = 1'b0;
        #1 chk_reset();
        ack_delay = 2;
        push_nop(32'h0);
        push_nop(32'h4);
        @(negedge CLK);
        RST = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge CLK);
            chk("wait_req", {31'd0, IMEM_REQ}, 32'd1);
        end
        @(negedge CLK);
        chk("wait_valid", {31'd0, INSTR_VALID}, 32'd1);
        chk("wait_err", {31'd0, FETCH_ERR}, 32'd0);
        RETIRE = 1'b1;
        repeat (4) @(negedge CLK);
        chk("wait2_valid", {31'd0, INSTR_VALID}, 32'd1);
        chk("wait2_err", {31'd0, FETCH_ERR}, 32'd0);

        // Reset in FETCH with the ACK still pending
        @(negedge CLK);
        chk("midfetch_addr", IMEM_ADDR, 32'h8);
        chk("midfetch_req", {31'd0, IMEM_REQ}, 32'd1);
        RST = 1'b0;
        #1 chk_reset();
        RETIRE = 1'b0; ack_delay = 0;
        push_nop(32'h0);
        push_nop(32'hFFFF_FFFC);
        push_nop(32'h0);
        @(negedge CLK);
        RST = 1'b1;
        #1 chk("rel_idle_req", {31'd0, IMEM_REQ}, 32'd0);
        @(negedge CLK);
        chk("rel_req", {31'd0, IMEM_REQ}, 32'd1);
        chk("rel_addr", IMEM_ADDR, 32'h0);

        // PC wraps from 0xFFFF_FFFC to 0
        @(negedge CLK);
        RETIRE = 1'b1; PC_SRC = 1'b1; BR_TARGET = 32'hFFFF_FFFC;
        @(negedge CLK);
        chk("wrap_fetch_addr", IMEM_ADDR, 32'hFFFF_FFFC);
        PC_SRC = 1'b0;
        @(negedge CLK);
        chk("wrap_pc_plus4", PC_PLUS4, 32'h0);
        @(negedge CLK);
        chk("wrap_addr", IMEM_ADDR, 32'h0);
        chk("wrap_misalign", {31'd0, MISALIGN}, 32'd0);
        @(negedge CLK);
        RETIRE = 1'b0;
        repeat (2) @(negedge CLK);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the single-cycle RV32I core, sitting directly upstream of the control unit and datapath. Holds the program counter and fetches one instruction per retire from instruction memory over a request/acknowledge handshake. Presents the instruction and its decoded opcode/funct fields to the control unit. Computes the next PC from the control unit's `PC_SRC`/`JALR` decisions and the datapath's target addresses.

## Interface
- `RESET_PC`, 32'h0000_0000: PC value loaded on reset.
- `TIMEOUT`, 16: maximum consecutive FETCH cycles without `IMEM_ACK` before a fetch error; 0 disables the check.
- `CLK`  in  1  clock; all state updates on the rising edge.
- `RST`  in  1  reset, asynchronous, active-low.
- `IMEM_ADDR`  out  32  fetch address; equals `PC`.
- `IMEM_REQ`  out  1  fetch request, held high until acknowledged.
- `IMEM_RDATA`  in  32  instruction word; sampled only in a cycle with `IMEM_ACK`=1 while in FETCH.
- `IMEM_ACK`  in  1  memory acknowledge.
- `RETIRE`  in  1  datapath has completed the presented instruction; accepted only in ISSUE.
- `PC_SRC`  in  1  from control unit: 0 = sequential, 1 = redirect.
- `JALR`  in  1  from control unit: selects `JALR_TARGET` when `PC_SRC`=1.
- `BR_TARGET`  in  32  PC-relative target (JAL/BNE).
- `JALR_TARGET`  in  32  rs1+imm target (JALR).
- `PC`  out  32  address of the presented instruction.
- `PC_PLUS4`  out  32  `PC`+4 (modulo 2^32), link value for JAL/JALR.
- `INSTR`  out  32  latched instruction word.
- `INSTR_VALID`  out  1  `INSTR` is valid and awaiting retire.
- `OPCODE`  out  7  `INSTR[6:0]` when valid, else 0.
- `FUNCT3`  out  3  `INSTR[14:12]` when valid, else 0.
- `FUNCT7`  out  1  `INSTR[30]` when valid, else 0.
- `MISALIGN`  out  1  sticky: a redirect produced a target with bits [1:0] ≠ 0.
- `FETCH_ERR`  out  1  sticky: fetch timeout.

## Operation
- States: IDLE, FETCH, ISSUE, HALT.
- IDLE: entered on reset; unconditionally → FETCH next cycle. Outputs inactive.
- FETCH: `IMEM_REQ`=1, `IMEM_ADDR`=`PC`. On `IMEM_ACK`=1: `INSTR` ← `IMEM_RDATA`, clear timeout counter, → ISSUE. Otherwise increment counter; if `TIMEOUT`≠0 and counter reaches `TIMEOUT`, set `FETCH_ERR` and → HALT.
- ISSUE: `INSTR_VALID`=1, `IMEM_REQ`=0. On `RETIRE`=1, compute next PC:
  - `PC_SRC`=0 → `PC`+4.
  - `PC_SRC`=1, `JALR`=0 → `BR_TARGET`.
  - `PC_SRC`=1, `JALR`=1 → `{JALR_TARGET[31:1],1'b0}`.
  - If next PC[1:0]≠0: `PC` unchanged, set `MISALIGN`, → HALT. Otherwise `PC` ← next PC, → FETCH.
- HALT: no requests, `INSTR_VALID`=0; exits only on reset.
- Field gating: `OPCODE`/`FUNCT3`/`FUNCT7` are 0 whenever `INSTR_VALID`=0. Opcode 0 drives the control unit into its all-zero default, so no register or memory writes occur between instructions.
- `IMEM_ACK` outside FETCH and `RETIRE` outside ISSUE are ignored.
- `JALR` with `PC_SRC`=0 is treated as sequential.
- PC arithmetic is 32-bit and wraps: 32'hFFFF_FFFC + 4 = 0.

## Timing
- Reset values (while `RST`=0): state IDLE, `PC`=`RESET_PC`, `PC_PLUS4`=`RESET_PC`+4, `INSTR`=0, `INSTR_VALID`=0, `IMEM_REQ`=0, field outputs 0, `MISALIGN`=0, `FETCH_ERR`=0, timeout counter 0.
- Reset asserted mid-fetch or mid-issue: immediate return to reset values; the pending request is dropped.
- `IMEM_REQ`, `INSTR_VALID`, and field outputs are decoded from registered state. `PC_PLUS4` is combinational from `PC`.
- Zero-wait memory (ACK in the first FETCH cycle) gives ISSUE on the next cycle. With `RETIRE` in the first ISSUE cycle, throughput is 2 cycles per instruction.
- Each additional ACK wait cycle adds one cycle. `RETIRE` may be delayed arbitrarily; `INSTR`/`PC` stay stable until it arrives.
- A redirect takes effect on `IMEM_ADDR` in the cycle after `RETIRE`.

## Test plan
- Reset with `RESET_PC`=0, zero-wait memory returning 0x00000013 at every address, `RETIRE` held high → `IMEM_ADDR` sequence 0,4,8,…; `INSTR_VALID` toggles every cycle; `OPCODE`=7'b0010011 in ISSUE cycles, 0 otherwise.
- In ISSUE at `PC`=0x10: `PC_SRC`=1, `JALR`=0, `BR_TARGET`=0x40, `RETIRE`=1 → next cycle `IMEM_ADDR`=0x40; `PC_PLUS4` was 0x14 during ISSUE.
- `PC_SRC`=1, `JALR`=1, `JALR_TARGET`=0x101 → next `PC`=0x100, `MISALIGN`=0.
- `PC_SRC`=1, `JALR`=0, `BR_TARGET`=0x102 → `MISALIGN`=1, state HALT, `PC` unchanged, `IMEM_REQ` stays 0 until `RST` is pulsed low.
- `TIMEOUT`=4, `IMEM_ACK` held 0 → `FETCH_ERR`=1 after 4 FETCH cycles, `IMEM_REQ` drops. In a second run, ACK on the 3rd cycle → no error, `INSTR` latched.
- `RST` driven low while in FETCH with ACK pending → all outputs at reset values in the same cycle. After release: one IDLE cycle, then a fetch from `RESET_PC`.
